// File: rtl/stream_pkg.sv
// -----------------------------------------------------------------------------
// stream_pkg
//   Shared types and elaboration helpers for the FIFO-side stream blocks.
//
//   Contents:
//     unpk_state_e  - two-state job controller encoding for fifo_unpacker
//     lanes_f       - number of OUT_WIDTH lanes packed into one IN_WIDTH word
//     lane_w_f      - width of a lane index (never narrower than one bit)
//     cfg_ok_f      - legality check for an IN_WIDTH / OUT_WIDTH pairing
// -----------------------------------------------------------------------------
package stream_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } unpk_state_e;

  // Lanes per packed word; returns 0 for a degenerate element width so the
  // legality check below can reject it instead of dividing by zero.
  function automatic int lanes_f(input int in_w, input int out_w);
    if (out_w <= 0) return 0;
    return in_w / out_w;
  endfunction

  // A single-lane word still needs a one-bit lane register.
  function automatic int lane_w_f(input int lanes);
    if (lanes <= 2) return 1;
    return $clog2(lanes);
  endfunction

  // The packed word must split into a whole number of elements, at least one.
  function automatic bit cfg_ok_f(input int in_w, input int out_w);
    if (out_w <= 0) return 1'b0;
    if (in_w % out_w != 0) return 1'b0;
    return lanes_f(in_w, out_w) >= 1;
  endfunction

endpackage : stream_pkg

// File: rtl/fifo_unpacker.sv
// -----------------------------------------------------------------------------
// fifo_unpacker
//   Pops IN_WIDTH-bit packed words from an FWFT FIFO and emits OUT_WIDTH-bit
//   elements on a valid/ready stream, lowest lane first. A job is bounded by a
//   programmed element count; a partial final word is popped after its last
//   used lane and its remaining lanes are dropped.
//
//   Ports:
//     clk          clock, all logic on the rising edge
//     rstn         asynchronous active-low reset
//     start        one-cycle job launch, honoured only while idle
//     total_elems  element count of the job, sampled when start is accepted
//     busy         high while a job is running
//     done         one-cycle pulse after the final element handshake
//     fifo_dout    head word of the FWFT FIFO
//     fifo_empty   FIFO empty flag
//     fifo_pop     pop strobe, same cycle as the handshake that retires a word
//     out_valid    element valid
//     out_data     element value
//     out_last     marks the final element of the job
//     out_ready    downstream accept
// -----------------------------------------------------------------------------
module fifo_unpacker
  import stream_pkg::*;
#(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 16,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [CNT_W-1:0]     total_elems,
  output logic                 busy,
  output logic                 done,
  input  logic [IN_WIDTH-1:0]  fifo_dout,
  input  logic                 fifo_empty,
  output logic                 fifo_pop,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  input  logic                 out_ready
);

  localparam int                LANES     = lanes_f(IN_WIDTH, OUT_WIDTH);
  localparam int                LANE_W    = lane_w_f(LANES);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [LANE_W-1:0] LANE_ONE  = LANE_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = '0;

  // ---------------------------------------------------------------------------
  // Elaboration-time configuration checks
  // ---------------------------------------------------------------------------
  if (!cfg_ok_f(IN_WIDTH, OUT_WIDTH)) begin : g_cfg_err
    $error("fifo_unpacker: IN_WIDTH must be a non-zero multiple of OUT_WIDTH");
  end

  if (CNT_W < 1) begin : g_cnt_err
    $error("fifo_unpacker: CNT_W must be at least 1");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  unpk_state_e             state_q,     state_d;
  logic [LANE_W-1:0]       lane_q,      lane_d;
  logic [CNT_W-1:0]        remaining_q, remaining_d;
  logic                    done_q,      done_d;

  // Stream-side decode shared by next-state and output logic.
  logic                    hs;          // element accepted this cycle
  logic                    final_elem;  // the head element is the job's last
  logic                    word_end;    // the head element retires its word

  assign final_elem = (remaining_q == CNT_ONE);
  assign word_end   = (lane_q == LAST_LANE) || final_elem;
  assign hs         = out_valid && out_ready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      lane_q      <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable assigned here gets a default first; a path that left
  // one unassigned would infer a latch to hold its old value.
  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (total_elems != CNT_ZERO) begin
            remaining_d = total_elems;
            lane_d      = '0;
            state_d     = RUN;
          end else begin
            // An empty job completes immediately without touching the FIFO.
            done_d = 1'b1;
          end
        end
      end

      RUN: begin
        // start is deliberately ignored here: the running count is never
        // reloaded. remaining only decrements on a handshake with
        // remaining >= 1, and the job exits on remaining == 1, so the counter
        // cannot wrap.
        if (hs) begin
          remaining_d = remaining_q - CNT_ONE;
          lane_d      = word_end ? '0 : lane_q + LANE_ONE;
          if (final_elem) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    busy      = (state_q == RUN);
    // Zero-latency path from the FWFT head: valid follows the empty flag
    // directly, so an underrun simply drops valid and freezes all state.
    out_valid = (state_q == RUN) && !fifo_empty;
    out_last  = out_valid && final_elem;
    // The word is released in the same cycle its last used lane is accepted;
    // hs already implies RUN and a non-empty FIFO.
    fifo_pop  = hs && word_end;
    done      = done_q;
    // Lane mux; the value is don't-care while out_valid is low.
    out_data  = fifo_dout[int'(lane_q) * OUT_WIDTH +: OUT_WIDTH];
  end

endmodule : fifo_unpacker

// File: tb/tb_fifo_unpacker.sv
// -----------------------------------------------------------------------------
// tb_fifo_unpacker
//   Directed self-checking bench for fifo_unpacker (64-bit words, 16-bit
//   elements). A small behavioural FWFT FIFO feeds the DUT; expected element
//   values, pop cycles and completion timing are hand-derived constants.
// -----------------------------------------------------------------------------
module tb_fifo_unpacker;

  localparam int IN_WIDTH  = 64;
  localparam int OUT_WIDTH = 16;
  localparam int CNT_W     = 16;

  localparam logic [63:0] WORD0 = 64'h0004_0003_0002_0001;
  localparam logic [63:0] WORD1 = 64'h0008_0007_0006_0005;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 start;
  logic [CNT_W-1:0]     total_elems;
  logic                 busy;
  logic                 done;
  logic [IN_WIDTH-1:0]  fifo_dout;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic                 out_valid;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_last;
  logic                 out_ready;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fifo_unpacker #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .total_elems (total_elems),
    .busy        (busy),
    .done        (done),
    .fifo_dout   (fifo_dout),
    .fifo_empty  (fifo_empty),
    .fifo_pop    (fifo_pop),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_ready   (out_ready)
  );

  // ---------------------------------------------------------------------------
  // Behavioural FWFT FIFO: writes from the stimulus process, reads on pop.
  // ---------------------------------------------------------------------------
  logic [63:0] mem [8];
  int          wr_ptr       = 0;
  int          rd_ptr       = 0;
  int          pop_cnt      = 0;
  int          pop_on_empty = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_dout  = mem[rd_ptr[2:0]];

  always @(posedge clk) begin
    if (fifo_pop) begin
      pop_cnt <= pop_cnt + 1;
      if (wr_ptr == rd_ptr) pop_on_empty <= pop_on_empty + 1;
      else                  rd_ptr       <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [63:0] w);
    mem[wr_ptr[2:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  // ---------------------------------------------------------------------------
  // Checking and sequencing helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk = n_chk + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int n);
    start       = 1'b1;
    total_elems = CNT_W'(n);
    tick();
    start       = 1'b0;
    total_elems = '0;
  endtask

  // One element with out_ready held high, then advance a cycle.
  task automatic expect_elem(input string tc, input int v, input bit pop,
                             input bit last);
    #1;
    check($sformatf("%s_e%0d_valid", tc, v), out_valid, 1);
    check($sformatf("%s_e%0d_data",  tc, v), out_data,  v);
    check($sformatf("%s_e%0d_pop",   tc, v), fifo_pop,  pop);
    check($sformatf("%s_e%0d_last",  tc, v), out_last,  last);
    check($sformatf("%s_e%0d_busy",  tc, v), busy,      1);
    tick();
  endtask

  // done pulses for exactly one cycle with the block back in IDLE.
  task automatic expect_done(input string tc);
    #1;
    check({tc, "_done_hi"},  done,      1);
    check({tc, "_busy_lo"},  busy,      0);
    check({tc, "_valid_lo"}, out_valid, 0);
    tick();
    #1;
    check({tc, "_done_lo"},  done,      0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int pops0;
    int nxt;
    bit prev_stall;
    logic [15:0] prev_data;

    rstn        = 1'b0;
    start       = 1'b0;
    total_elems = '0;
    out_ready   = 1'b1;

    // Reset state
    #2;
    check("rst_busy",  busy,      0);
    check("rst_done",  done,      0);
    check("rst_pop",   fifo_pop,  0);
    check("rst_valid", out_valid, 0);
    check("rst_last",  out_last,  0);
    #10;
    rstn = 1'b1;
    tick();

    // 1. Full words, no stall
    push(WORD0);
    push(WORD1);
    pops0 = pop_cnt;
    start_job(8);
    for (int i = 1; i <= 8; i++)
      expect_elem("t1", i, (i == 4) || (i == 8), i == 8);
    expect_done("t1");
    check("t1_pops",  pop_cnt - pops0, 2);
    check("t1_empty", fifo_empty, 1);
    tick();

    // 2. Partial final word
    push(WORD0);
    push(WORD1);
    pops0 = pop_cnt;
    start_job(6);
    for (int i = 1; i <= 6; i++)
      expect_elem("t2", i, (i == 4) || (i == 6), i == 6);
    expect_done("t2");
    check("t2_pops",  pop_cnt - pops0, 2);
    check("t2_empty", fifo_empty, 1);
    tick();

    // 3. Backpressure: out_ready follows 1,0,0 repeating
    push(WORD0);
    push(WORD1);
    pops0      = pop_cnt;
    nxt        = 1;
    prev_stall = 1'b0;
    prev_data  = '0;
    start_job(8);
    for (int k = 0; k < 60 && nxt <= 8; k++) begin
      out_ready = (k % 3 == 0);
      #1;
      if (prev_stall) begin
        check($sformatf("t3_hold_valid_k%0d", k), out_valid, 1);
        check($sformatf("t3_hold_data_k%0d", k), out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        check($sformatf("t3_data_%0d", nxt), out_data, nxt);
        check($sformatf("t3_pop_%0d",  nxt), fifo_pop, (nxt == 4) || (nxt == 8));
        nxt = nxt + 1;
      end else begin
        check($sformatf("t3_nopop_k%0d", k), fifo_pop, 0);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      tick();
    end
    out_ready = 1'b1;
    check("t3_count", nxt, 9);
    expect_done("t3");
    check("t3_pops", pop_cnt - pops0, 2);
    tick();

    // 4. FIFO underrun between words
    push(WORD0);
    pops0 = pop_cnt;
    start_job(8);
    for (int i = 1; i <= 4; i++)
      expect_elem("t4", i, i == 4, 1'b0);
    for (int g = 0; g < 5; g++) begin
      #1;
      check($sformatf("t4_gap%0d_valid", g), out_valid, 0);
      check($sformatf("t4_gap%0d_pop",   g), fifo_pop,  0);
      check($sformatf("t4_gap%0d_busy",  g), busy,      1);
      check($sformatf("t4_gap%0d_lane",  g), dut.lane_q, 0);
      check($sformatf("t4_gap%0d_rem",   g), dut.remaining_q, 4);
      tick();
    end
    push(WORD1);
    for (int i = 5; i <= 8; i++)
      expect_elem("t4", i, i == 8, i == 8);
    expect_done("t4");
    check("t4_pops", pop_cnt - pops0, 2);
    tick();

    // 5a. Zero-length job
    start_job(0);
    expect_done("t5a");
    tick();

    // 5b. start while running is ignored
    push(WORD0);
    start_job(4);
    expect_elem("t5b", 1, 1'b0, 1'b0);
    start       = 1'b1;
    total_elems = CNT_W'(3);
    expect_elem("t5b", 2, 1'b0, 1'b0);
    start       = 1'b0;
    total_elems = '0;
    #1;
    check("t5b_rem_kept", dut.remaining_q, 2);
    expect_elem("t5b", 3, 1'b0, 1'b0);
    expect_elem("t5b", 4, 1'b1, 1'b1);
    expect_done("t5b");
    tick();

    // 6. Reset mid-job, then restart on the unpopped head word
    push(WORD0);
    push(WORD1);
    pops0 = pop_cnt;
    start_job(8);
    expect_elem("t6", 1, 1'b0, 1'b0);
    expect_elem("t6", 2, 1'b0, 1'b0);
    rstn = 1'b0;
    #1;
    check("t6_rst_busy",  busy,      0);
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_done",  done,      0);
    check("t6_rst_pop",   fifo_pop,  0);
    #1;
    rstn = 1'b1;
    tick();
    start_job(2);
    expect_elem("t6", 1, 1'b0, 1'b0);
    expect_elem("t6", 2, 1'b1, 1'b1);
    expect_done("t6");
    check("t6_pops",     pop_cnt - pops0, 1);
    check("t6_head",     fifo_dout, WORD1);
    check("pop_on_empty", pop_on_empty, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global time bound so a stuck run still terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule : tb_fifo_unpacker

// File: doc/fifo_unpacker.md
Name: fifo_unpacker

Overview:
Downstream consumer of the register-array FWFT FIFO (`FIFO`). It pops IN_WIDTH-bit packed words from the FIFO and emits OUT_WIDTH-bit elements on a valid/ready stream, LSB lane first. Each job is bounded by a programmed element count. A partial final word is popped and its unused lanes are discarded. Typical use: unpacking 64-bit memory words into 16-bit Frodo/Scloud matrix coefficients for the compute array.

Parameters:
IN_WIDTH, 64, packed word width; must equal the upstream FIFO WIDTH.
OUT_WIDTH, 16, element width; IN_WIDTH must be an integer multiple of OUT_WIDTH.
CNT_W, 16, width of the element-count field.

Ports:
clk  in  1  clock; all logic on posedge.
rstn  in  1  reset; asynchronous, active-low.
start  in  1  one-cycle job launch; honoured only in IDLE.
total_elems  in  CNT_W  element count for the job; sampled when start is accepted.
busy  out  1  high while state is RUN.
done  out  1  one-cycle pulse at job completion.
fifo_dout  in  IN_WIDTH  FWFT head word from the FIFO.
fifo_empty  in  1  FIFO empty flag.
fifo_pop  out  1  pop strobe to the FIFO.
out_valid  out  1  element valid.
out_data  out  OUT_WIDTH  element value.
out_last  out  1  marks the final element of the job.
out_ready  in  1  downstream accept.

Behaviour:
- Derived constants:
  - LANES = IN_WIDTH/OUT_WIDTH.
  - LANE_W = max(1, $clog2(LANES)).
- Registers:
  - state in {IDLE, RUN}.
  - lane (LANE_W bits).
  - remaining (CNT_W bits).
  - done_q.
- Reset (async, rstn=0):
  - state=IDLE, lane=0, remaining=0, done_q=0.
  - Outputs: busy=0, done=0, fifo_pop=0, out_valid=0, out_last=0, out_data=don't-care (any value).
- IDLE:
  - start=1 with total_elems!=0: remaining<=total_elems, lane<=0, go to RUN.
  - start=1 with total_elems==0: stay in IDLE, done pulses on the next cycle.
- RUN:
  - out_valid = !fifo_empty (combinational).
  - out_data = fifo_dout[lane*OUT_WIDTH +: OUT_WIDTH].
  - out_last = out_valid && (remaining==1).
  - busy = 1.
- Handshake: hs = out_valid && out_ready.
  - On hs: remaining<=remaining-1.
  - On hs with lane==LANES-1 or remaining==1: lane<=0.
  - On any other hs: lane<=lane+1.
- fifo_pop = (state==RUN) && hs && (lane==LANES-1 || remaining==1).
  - Combinational, so it is same-cycle with the final lane handshake.
  - Never asserted when fifo_empty=1.
- Completion: hs with remaining==1 -> state<=IDLE, done_q<=1. done = done_q, high for exactly one cycle.
- Latency: zero-cycle from FIFO head to out_valid. A full word yields LANES elements in LANES cycles when out_ready is held high.
- Stalls and backpressure:
  - out_ready=0: out_data and lane hold stable while out_valid=1, and no pop occurs.
  - fifo_empty=1 mid-job: out_valid=0 and all state holds.
- Partial final word: when total_elems is not a multiple of LANES, the last word is popped after its last used lane. Remaining lanes are dropped.
- Start while RUN is ignored; remaining is not reloaded.
- Count wrap: remaining is never decremented below 1 within RUN, so CNT_W arithmetic cannot wrap.
- Reset mid-job: returns to IDLE immediately. The FIFO is not flushed by this block, and the already-popped word is lost.
- Back-to-back jobs: start may be asserted in the cycle done is high; the new job starts at lane 0.

Decomposition:
- Package `stream_pkg` holds:
  - the `unpk_state_e` enum {IDLE, RUN};
  - a `lanes_f(in_w, out_w)` function;
  - elaboration assertions (IN_WIDTH % OUT_WIDTH == 0, LANES >= 1).
- No sub-module. The lane mux is a single indexed part-select, and the FIFO is instantiated by the parent, not inside this block.

Test Plan:
1. Full words, no stall: IN=64, OUT=16, FIFO preloaded with 0x0004_0003_0002_0001 and 0x0008_0007_0006_0005, total_elems=8, out_ready=1 -> out_data 1..8 on consecutive cycles; fifo_pop on cycles 4 and 8; out_last and hs on element 8; done one cycle later; busy low after.
2. Partial word: total_elems=6, same data -> elements 1..6; second pop coincides with element 6; lanes 7 and 8 never appear; FIFO empty afterwards.
3. Backpressure: out_ready toggles 1,0,0,1,... -> each element held stable while out_ready=0; no duplicated or skipped elements; pop count is 2.
4. FIFO underrun: push the second word 5 cycles after the first is exhausted -> out_valid=0 during the gap; lane=0 and remaining=4 are held; the stream resumes with 5.
5. Zero count and ignored start: total_elems=0 -> no out_valid, done pulse one cycle later. A start pulse mid-job with total_elems=3 -> no effect; original count completes.
6. Reset mid-job: deassert rstn after element 2 -> busy=0, out_valid=0, done=0 asynchronously; a new start with total_elems=2 restarts at lane 0 of the current FIFO head.
